// File: rtl/chip8_pkg.sv
// Shared types and helpers for the CHIP-8 draw engine.
// Framebuffer geometry, draw FSM states, pixel indexing.
package chip8_pkg;

    localparam int DISPLAY_W = 64;
    localparam int DISPLAY_H = 32;
    localparam int DISPLAY_N = DISPLAY_W * DISPLAY_H;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FETCH,
        S_DRAW,
        S_FINISH
    } draw_state_t;

    function automatic logic [10:0] pix_idx(
        input logic [5:0] x,
        input logic [4:0] y
    );
        return 11'(y) * 11'(DISPLAY_W) + 11'(x);
    endfunction

endpackage

// File: rtl/chip8_draw_row.sv
// XOR of one sprite byte into one 64-pixel framebuffer row.
// Handles horizontal clip/wrap and reports pixel collisions.
module chip8_draw_row
    import chip8_pkg::*;
#(
    parameter bit WRAP_PIXELS = 1'b0
) (
    input  logic [DISPLAY_W-1:0] old_row,
    input  logic [7:0]           sprite,
    input  logic [5:0]           x0,
    output logic [DISPLAY_W-1:0] new_row,
    output logic                 hit
);

    logic [DISPLAY_W-1:0] mask;

    // Build the set of target columns, then XOR and detect overlap
    always_comb begin
        mask = '0;
        for (int k = 0; k < 8; k++) begin
            logic [6:0] col;
            col = {1'b0, x0} + 7'(k);
            if (sprite[7-k] && (WRAP_PIXELS || !col[6])) begin
                mask[col[5:0]] = 1'b1;
            end
        end
        new_row = old_row ^ mask;
        hit     = |(old_row & mask);
    end

endmodule

// File: rtl/chip8_draw_unit.sv
// CHIP-8 sprite draw engine: DXYN and 00E0 on a 64x32 framebuffer.
// Fetches one sprite byte per row and XORs it in on the next cycle.
module chip8_draw_unit
    import chip8_pkg::*;
#(
    parameter bit WRAP_PIXELS = 1'b0,
    parameter int ADDR_W      = 12
) (
    input  logic                 instruction_clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 clear,
    input  logic [7:0]           vx,
    input  logic [7:0]           vy,
    input  logic [3:0]           n,
    input  logic [ADDR_W-1:0]    i_addr,
    output logic                 mem_rd,
    output logic [ADDR_W-1:0]    mem_addr,
    input  logic [7:0]           mem_data,
    output logic                 busy,
    output logic                 done,
    output logic                 collision,
    output logic [DISPLAY_N-1:0] display
);

    draw_state_t       state;
    draw_state_t       state_nxt;
    logic [5:0]        x0;
    logic [4:0]        y0;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] fetch_addr;
    logic [3:0]        rows;
    logic [3:0]        row;
    logic [3:0]        next_row;
    logic [5:0]        ty;
    logic              row_ok;
    logic [10:0]       row_base;
    logic [DISPLAY_W-1:0] old_row;
    logic [DISPLAY_W-1:0] new_row;
    logic              hit;

    assign next_row   = row + 4'd1;
    assign fetch_addr = base + ADDR_W'(row);
    assign ty         = {1'b0, y0} + {2'b00, row};
    assign row_ok     = WRAP_PIXELS || !ty[5];
    assign row_base   = pix_idx(6'd0, ty[4:0]);
    assign old_row    = display[row_base +: DISPLAY_W];

    assign busy     = (state != S_IDLE);
    assign done     = (state == S_FINISH);
    assign mem_rd   = (state == S_FETCH);
    assign mem_addr = mem_rd ? fetch_addr : addr_q;

    chip8_draw_row #(
        .WRAP_PIXELS(WRAP_PIXELS)
    ) u_row (
        .old_row(old_row),
        .sprite (mem_data),
        .x0     (x0),
        .new_row(new_row),
        .hit    (hit)
    );

    // State register
    always_ff @(posedge instruction_clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; clear has priority over start in IDLE
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (clear)
                    state_nxt = S_CLEAR;
                else if (start)
                    state_nxt = (n != 4'd0) ? S_FETCH : S_FINISH;
            end
            S_CLEAR:  state_nxt = S_FINISH;
            S_FETCH:  state_nxt = S_DRAW;
            S_DRAW:   state_nxt = (next_row < rows) ? S_FETCH : S_FINISH;
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Datapath: latch request, track row, update framebuffer and VF
    always_ff @(posedge instruction_clk or posedge rst) begin
        if (rst) begin
            x0        <= '0;
            y0        <= '0;
            base      <= '0;
            rows      <= '0;
            row       <= '0;
            addr_q    <= '0;
            collision <= 1'b0;
            display   <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (clear) begin
                        display   <= '0;
                        collision <= 1'b0;
                    end else if (start) begin
                        x0        <= 6'(vx % 8'(DISPLAY_W));
                        y0        <= 5'(vy % 8'(DISPLAY_H));
                        base      <= i_addr;
                        rows      <= n;
                        row       <= '0;
                        collision <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    display   <= '0;
                    collision <= 1'b0;
                end
                S_FETCH: addr_q <= fetch_addr;
                S_DRAW: begin
                    if (row_ok) begin
                        display[row_base +: DISPLAY_W] <= new_row;
                        if (hit) collision <= 1'b1;
                    end
                    row <= next_row;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_chip8_draw_unit.sv
// Self-checking bench for chip8_draw_unit, clip and wrap variants.
// Pixel-level reference model driven by directed and random draws.
module tb_chip8_draw_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        clear = 1'b0;
    logic [7:0]  vx = '0;
    logic [7:0]  vy = '0;
    logic [3:0]  n = '0;
    logic [11:0] i_addr = '0;

    logic        mem_rd_w   [2];
    logic [11:0] mem_addr_w [2];
    logic [7:0]  mem_data_w [2];
    logic        busy_w     [2];
    logic        done_w     [2];
    logic        col_w      [2];
    logic [2047:0] disp_w   [2];

    logic [7:0]    ram [4096];
    logic [2047:0] exp_disp [2];
    logic          exp_col  [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    chip8_draw_unit #(.WRAP_PIXELS(1'b0), .ADDR_W(12)) u0 (
        .instruction_clk(clk), .rst(rst), .start(start), .clear(clear),
        .vx(vx), .vy(vy), .n(n), .i_addr(i_addr),
        .mem_rd(mem_rd_w[0]), .mem_addr(mem_addr_w[0]),
        .mem_data(mem_data_w[0]), .busy(busy_w[0]), .done(done_w[0]),
        .collision(col_w[0]), .display(disp_w[0])
    );

    chip8_draw_unit #(.WRAP_PIXELS(1'b1), .ADDR_W(12)) u1 (
        .instruction_clk(clk), .rst(rst), .start(start), .clear(clear),
        .vx(vx), .vy(vy), .n(n), .i_addr(i_addr),
        .mem_rd(mem_rd_w[1]), .mem_addr(mem_addr_w[1]),
        .mem_data(mem_data_w[1]), .busy(busy_w[1]), .done(done_w[1]),
        .collision(col_w[1]), .display(disp_w[1])
    );

    // Synchronous RAM read ports, one per DUT
    always @(posedge clk) begin
        if (mem_rd_w[0]) mem_data_w[0] <= ram[mem_addr_w[0]];
        if (mem_rd_w[1]) mem_data_w[1] <= ram[mem_addr_w[1]];
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_disp(input string tag, input logic [2047:0] obs,
                            input logic [2047:0] exp_v);
        int first;
        first = -1;
        for (int i = 2047; i >= 0; i--)
            if (obs[i] !== exp_v[i]) first = i;
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s ones obs=%0d exp=%0d first_diff=%0d",
                   tag, $countones(obs), $countones(exp_v), first);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            exp_disp[d] = '0;
            exp_col[d]  = 1'b0;
        end
    endtask

    task automatic run_op(input string tag, input bit is_clr,
                          input bit with_start, input logic [7:0] vx_i,
                          input logic [7:0] vy_i, input logic [3:0] n_i,
                          input logic [11:0] ia, input bit poke);
        int lat;
        int nexp;
        logic [11:0] exp_rd [16];
        int dcyc [2];
        int dcnt [2];
        int bcnt [2];
        int rdn  [2];
        logic [11:0] rd [2][40];
        nexp = 0;
        if (is_clr) begin
            lat = 2;
            model_reset();
        end else begin
            lat = (n_i == 0) ? 1 : 2 * int'(n_i) + 1;
            for (int d = 0; d < 2; d++) exp_col[d] = 1'b0;
            for (int r = 0; r < int'(n_i); r++) begin
                logic [11:0] a;
                logic [7:0]  b;
                a = 12'((int'(ia) + r) % 4096);
                exp_rd[nexp] = a;
                nexp++;
                b = ram[a];
                for (int k = 0; k < 8; k++) begin
                    if (b[7-k]) begin
                        for (int d = 0; d < 2; d++) begin
                            int x;
                            int y;
                            x = int'(vx_i) % 64 + k;
                            y = int'(vy_i) % 32 + r;
                            if (d == 1) begin
                                x = x % 64;
                                y = y % 32;
                            end
                            if (x < 64 && y < 32) begin
                                if (exp_disp[d][y*64+x]) exp_col[d] = 1'b1;
                                exp_disp[d][y*64+x] = ~exp_disp[d][y*64+x];
                            end
                        end
                    end
                end
            end
        end
        for (int d = 0; d < 2; d++) begin
            dcyc[d] = 0;
            dcnt[d] = 0;
            bcnt[d] = 0;
            rdn[d]  = 0;
        end
        vx     = vx_i;
        vy     = vy_i;
        n      = n_i;
        i_addr = ia;
        clear  = is_clr;
        start  = !is_clr || with_start;
        @(negedge clk);
        start  = 1'b0;
        clear  = 1'b0;
        vx     = 8'($urandom);
        vy     = 8'($urandom);
        n      = 4'($urandom);
        i_addr = 12'($urandom);
        for (int cyc = 1; cyc <= lat + 3; cyc++) begin
            for (int d = 0; d < 2; d++) begin
                if (done_w[d] === 1'b1) begin
                    dcnt[d]++;
                    if (dcyc[d] == 0) dcyc[d] = cyc;
                end
                if (busy_w[d] === 1'b1) bcnt[d]++;
                if (mem_rd_w[d] === 1'b1) begin
                    if (rdn[d] < 40) rd[d][rdn[d]] = mem_addr_w[d];
                    rdn[d]++;
                end
            end
            if (poke && cyc == 3) start = 1'b1;
            if (poke && cyc == 4) start = 1'b0;
            @(negedge clk);
        end
        for (int d = 0; d < 2; d++) begin
            string p;
            p = $sformatf("%s/w%0d", tag, d);
            chk({p, "/done_cyc"}, dcyc[d], lat);
            chk({p, "/done_cnt"}, dcnt[d], 1);
            chk({p, "/busy_cyc"}, bcnt[d], lat);
            chk({p, "/reads"}, rdn[d], nexp);
            for (int r = 0; r < nexp && r < rdn[d]; r++)
                chk($sformatf("%s/rd%0d", p, r), 32'(rd[d][r]),
                    32'(exp_rd[r]));
            chk_disp({p, "/display"}, disp_w[d], exp_disp[d]);
            chk({p, "/collision"}, 32'(col_w[d]), 32'(exp_col[d]));
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            string p;
            p = $sformatf("%s/w%0d", tag, d);
            chk({p, "/busy"}, 32'(busy_w[d]), 0);
            chk({p, "/done"}, 32'(done_w[d]), 0);
            chk({p, "/collision"}, 32'(col_w[d]), 0);
            chk({p, "/mem_rd"}, 32'(mem_rd_w[d]), 0);
            chk({p, "/mem_addr"}, 32'(mem_addr_w[d]), 0);
            chk_disp({p, "/display"}, disp_w[d], '0);
        end
    endtask

    initial begin
        for (int a = 0; a < 4096; a++) ram[a] = 8'($urandom);
        ram[12'h050] = 8'hF0;
        ram[12'h051] = 8'h90;
        ram[12'h052] = 8'h90;
        ram[12'h053] = 8'h90;
        ram[12'h054] = 8'hF0;
        ram[12'h300] = 8'hFF;
        ram[12'h301] = 8'hFF;
        model_reset();

        repeat (3) @(negedge clk);
        chk_idle_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        run_op("font0", 0, 0, 8'd0, 8'd0, 4'd5, 12'h050, 0);
        chk("font0/row0_lo", 32'(disp_w[0][7:0]), 32'h0F);
        run_op("font0_again", 0, 0, 8'd0, 8'd0, 4'd5, 12'h050, 0);
        chk("font0_again/col", 32'(col_w[0]), 1);

        run_op("edge", 0, 0, 8'd62, 8'd31, 4'd2, 12'h300, 0);
        chk("edge/clip_62_31", 32'(disp_w[0][31*64+62]), 1);
        chk("edge/clip_0_31", 32'(disp_w[0][31*64+0]), 0);
        chk("edge/wrap_5_0", 32'(disp_w[1][0*64+5]), 1);

        run_op("clr_start", 1, 1, 8'd3, 8'd3, 4'd4, 12'h050, 0);

        run_op("mod_xy", 0, 0, 8'h47, 8'h25, 4'd1, 12'h050, 0);
        chk("mod_xy/px_7_5", 32'(disp_w[0][5*64+7]), 1);
        run_op("n_zero", 0, 0, 8'd20, 8'd9, 4'd0, 12'h050, 0);
        run_op("addr_wrap", 0, 0, 8'd30, 8'd12, 4'd2, 12'hFFF, 0);
        run_op("busy_poke", 0, 0, 8'd40, 8'd16, 4'd3, 12'h051, 1);

        for (int t = 0; t < 24; t++) begin
            run_op($sformatf("rnd%0d", t), ($urandom_range(0, 5) == 0),
                   1'($urandom), 8'($urandom), 8'($urandom),
                   4'($urandom), 12'($urandom), 0);
        end

        vx     = 8'd10;
        vy     = 8'd3;
        n      = 4'd5;
        i_addr = 12'h050;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc < 6; cyc++) @(negedge clk);
        rst = 1'b1;
        #1;
        chk_idle_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        run_op("after_rst", 0, 0, 8'd10, 8'd3, 4'd5, 12'h050, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
